// File: rtl/rc_filter_555_out.sv
// First-order RC low-pass that smooths the 555 VCO square wave, using a 16-cycle shift-add multiply.
// Optional output coupling-cap DC block: define RC_FILTER_DC_BLOCK_EN.
//
// state | meaning
// IDLE  | waiting for audio_clk_en
// MUL   | shift-add of diff * ALPHA_Q16, one alpha bit per clock
// ACC   | fold product into y_acc
// HP    | DC-block high-pass stage (only with RC_FILTER_DC_BLOCK_EN)
module rc_filter_555_out #(
    parameter int CLOCK_RATE  = 1000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int R_OHMS      = 10000,
    parameter int C_NF        = 100,
    parameter int HP_SHIFT    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [63:0] DT_NS      = 64'd1000000000 / 64'(SAMPLE_RATE);
    localparam logic [63:0] ALPHA_FULL = (64'd65536 * DT_NS) / (64'(R_OHMS) * 64'(C_NF) + DT_NS);
    localparam logic [15:0] ALPHA_Q16  = ALPHA_FULL[15:0];
`ifdef RC_FILTER_DC_BLOCK_EN
    localparam int MIN_SPACING = 19;
`else
    localparam int MIN_SPACING = 18;
`endif

    generate
        if (ALPHA_FULL == 64'd0 || ALPHA_FULL > 64'd65535) begin : g_alpha_err
            $error("rc_filter_555_out: ALPHA_Q16 out of range");
        end
        if (CLOCK_RATE / SAMPLE_RATE < MIN_SPACING) begin : g_rate_err
            $error("rc_filter_555_out: too few clocks per sample");
        end
        if (HP_SHIFT < 1 || HP_SHIFT > 15) begin : g_shift_err
            $error("rc_filter_555_out: HP_SHIFT out of range");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_HP} state_t;

    state_t             r_state, w_state_next;
    logic        [3:0]  r_cnt;
    logic signed [16:0] r_diff;
    logic signed [32:0] r_prod;
    logic signed [31:0] r_y_acc;
    logic signed [15:0] r_out;
    logic               r_out_valid;
    logic               r_overrun;

    logic signed [16:0] w_in_diff;
    logic signed [32:0] w_diff_ext;
    logic signed [32:0] w_addend;
    logic signed [31:0] w_y_next;

    assign w_in_diff  = {in[15], in} - {r_y_acc[31], r_y_acc[31:16]};
    assign w_diff_ext = {{16{r_diff[16]}}, r_diff};
    assign w_addend   = ALPHA_Q16[r_cnt] ? (w_diff_ext <<< r_cnt) : 33'sd0;
    // The convex update keeps y_acc in range, so dropping the product's top bit is exact.
    assign w_y_next   = r_y_acc + 32'(r_prod);

`ifdef RC_FILTER_DC_BLOCK_EN
    logic signed [31:0] r_dc_acc;
    logic signed [15:0] w_lp;
    logic signed [32:0] w_dc_err;
    logic signed [32:0] w_dc_step;
    logic signed [31:0] w_dc_next;
    logic signed [16:0] w_hp;
    logic signed [15:0] w_hp_sat;

    assign w_lp      = r_y_acc[31:16];
    assign w_dc_err  = {w_lp[15], w_lp, 16'h0000} - {r_dc_acc[31], r_dc_acc};
    assign w_dc_step = w_dc_err >>> HP_SHIFT;
    assign w_dc_next = r_dc_acc + 32'(w_dc_step);
    assign w_hp      = {w_lp[15], w_lp} - {w_dc_next[31], w_dc_next[31:16]};

    always_comb begin
        w_hp_sat = w_hp[15:0];
        if (w_hp[16] != w_hp[15]) begin
            w_hp_sat = w_hp[16] ? 16'sh8000 : 16'sh7fff;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (audio_clk_en) w_state_next = S_MUL;
            S_MUL:   if (r_cnt == 4'd15) w_state_next = S_ACC;
`ifdef RC_FILTER_DC_BLOCK_EN
            S_ACC:   w_state_next = S_HP;
`else
            S_ACC:   w_state_next = S_IDLE;
`endif
            S_HP:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_diff      <= 17'sd0;
            r_prod      <= 33'sd0;
            r_y_acc     <= 32'sd0;
            r_out       <= 16'sd0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef RC_FILTER_DC_BLOCK_EN
            r_dc_acc    <= 32'sd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;
            // Strobes during any non-idle cycle are dropped, not queued.
            if (audio_clk_en && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (audio_clk_en) begin
                        r_diff <= w_in_diff;
                        r_prod <= 33'sd0;
                        r_cnt  <= 4'd0;
                    end
                end
                S_MUL: begin
                    r_prod <= r_prod + w_addend;
                    r_cnt  <= r_cnt + 4'd1;
                end
                S_ACC: begin
                    r_y_acc <= w_y_next;
`ifndef RC_FILTER_DC_BLOCK_EN
                    r_out       <= w_y_next[31:16];
                    r_out_valid <= 1'b1;
`endif
                end
`ifdef RC_FILTER_DC_BLOCK_EN
                S_HP: begin
                    r_dc_acc    <= w_dc_next;
                    r_out       <= w_hp_sat;
                    r_out_valid <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_rc_filter_555_out.sv
// Scoreboard bench for rc_filter_555_out: random and directed samples against an arithmetic RC model.
module tb_rc_filter_555_out;

    logic               clk = 1'b0;
    logic               reset;
    logic               audio_clk_en;
    logic signed [15:0] in;
    logic signed [15:0] out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    always #5 clk = ~clk;

    rc_filter_555_out dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .in           (in),
        .out          (out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

`ifdef RC_FILTER_DC_BLOCK_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif
    localparam longint DT    = 64'd1000000000 / 48000;
    localparam longint ALPHA = (65536 * DT) / (10000 * 100 + DT);
    localparam int     HP_SH = 10;

    typedef struct {
        int edge_no;
        int value;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     edge_cnt = 0;
    int     busy_end = 0;
    int     n_out = 0;
    bit     mon_en = 1'b0;
    bit     m_ovr = 1'b0;
    longint m_y = 0;
    longint m_dc = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_near(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // Filter as plain arithmetic on a Q16.16 value held in a wide integer.
    function automatic int model_step(input int x);
        longint lp;
        longint v;
        m_y = m_y + (longint'(x) - (m_y >>> 16)) * ALPHA;
        lp  = m_y >>> 16;
        v   = lp;
`ifdef RC_FILTER_DC_BLOCK_EN
        m_dc = m_dc + (((lp * 65536) - m_dc) >>> HP_SH);
        v    = lp - (m_dc >>> 16);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return int'(v);
    endfunction

    task automatic tick(input bit en, input int x, input bit rst);
        int e;
        reset        = rst;
        audio_clk_en = en;
        in           = 16'(x);
        @(posedge clk);
        #1;
        e = edge_cnt;
        if (rst) begin
            m_y      = 0;
            m_dc     = 0;
            m_ovr    = 1'b0;
            busy_end = 0;
            sb.delete();
        end else if (en) begin
            if (e > busy_end) begin
                sb.push_back('{e + LAT, model_step(x)});
                busy_end = e + LAT;
            end else begin
                m_ovr = 1'b1;
            end
        end
        reset        = 1'b0;
        audio_clk_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, edge_cnt < busy_end);
            check("overrun", overrun, m_ovr);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got out=%0d expected no output", out);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("out_latency", edge_cnt, x.edge_no);
                    check("out_value", out, x.value);
                    n_out++;
                end
            end else if (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL missing_out_valid: got none expected at edge %0d", sb[0].edge_no);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int n0;
        reset        = 1'b1;
        audio_clk_en = 1'b0;
        in           = 16'sd0;
        repeat (3) tick(1'b0, 0, 1'b1);
        mon_en = 1'b1;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // single sample latency
        tick(1'b1, 16000, 1'b0);
        idle(LAT + 2);
        check("first_out", out, 326);
        check("first_busy", busy, 0);

        // step response
        tick(1'b0, 0, 1'b1);
        for (int n = 1; n <= 1000; n++) begin
            tick(1'b1, 16000, 1'b0);
            idle(19);
`ifndef RC_FILTER_DC_BLOCK_EN
            if (n == 49) check_near("step_49", out, 10114, 100);
`endif
        end
`ifndef RC_FILTER_DC_BLOCK_EN
        check("step_final", out, 16000);
`endif

        // full-scale swing
        tick(1'b0, 0, 1'b1);
        for (int n = 0; n < 700; n++) begin
            tick(1'b1, 32767, 1'b0);
            idle(19);
        end
        for (int n = 0; n < 700; n++) begin
            tick(1'b1, -32768, 1'b0);
            idle(19);
`ifndef RC_FILTER_DC_BLOCK_EN
            if (n == 0) check_near("swing_first", out, 32767 - 1336, 1);
`endif
        end
`ifndef RC_FILTER_DC_BLOCK_EN
        check("swing_final", out, -32768);
`endif

        // overrun: second strobe 5 clk after the first
        tick(1'b0, 0, 1'b1);
        n0 = n_out;
        tick(1'b1, 1000, 1'b0);
        idle(4);
        tick(1'b1, 5000, 1'b0);
        idle(25);
        check("ovr_flag", overrun, 1);
        check("ovr_outputs", n_out - n0, 1);
        for (int n = 0; n < 5; n++) begin
            tick(1'b1, 3000 * n - 6000, 1'b0);
            idle(19);
        end
        check("ovr_after", n_out - n0, 6);

        // reset asserted on edge E8 of a running sample
        tick(1'b0, 0, 1'b1);
        tick(1'b1, 5000, 1'b0);
        idle(LAT + 3);
        tick(1'b1, 20000, 1'b0);
        idle(7);
        tick(1'b0, 0, 1'b1);
        check("midrst_out", out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        idle(25);
        tick(1'b1, 16000, 1'b0);
        idle(LAT + 2);
        check("midrst_next", out, 326);

        // random samples, random spacing (some too close and dropped)
        for (int n = 0; n < 400; n++) begin
            tick(1'b1, int'($urandom_range(0, 65535)) - 32768, 1'b0);
            idle(int'($urandom_range(0, 30)));
        end
        idle(LAT + 5);
        check("drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1);
    end

endmodule
